// File: rtl/fetch_pc_scheduler.sv
// Fetch PC sequencer: one I-cache request at a time, redirect > prediction > sequential.
// Define FETCH_PERF_EN to add saturating fire/redirect counters.
module fetch_pc_scheduler #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_icacheReady,
  output logic        o_fetchValid,
  output logic [31:0] o_fetchPc_32,
  input  logic        i_blockValid,
  input  logic [4:0]  i_validSize_5,
  input  logic        i_predValid,
  input  logic [31:0] i_predPc_32,
  input  logic        i_bufferFull,
  input  logic        i_beRedirect,
  input  logic [31:0] i_beRedirectPc_32,
  output logic        o_fire,
  output logic        o_flush,
  output logic [1:0]  o_state_2
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] o_fireCount_16,
  output logic [15:0] o_redirectCount_16
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_WAIT  = 2'b10,
    S_FLUSH = 2'b11
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        drop_pending_q, drop_pending_d;
  logic        flush_q, flush_d;
  logic        redirect;

  assign redirect = i_beRedirect && (state_q != S_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    flush_cnt_d    = flush_cnt_q;
    drop_pending_d = drop_pending_q;
    flush_d        = 1'b0;
    o_fetchValid   = 1'b0;
    o_fire         = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        o_fetchValid = !i_beRedirect;
        if (!i_beRedirect && i_icacheReady) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_blockValid && !i_bufferFull && !i_beRedirect) begin
          o_fire  = 1'b1;
          state_d = S_REQ;
          pc_d    = i_predValid ? i_predPc_32 : pc_q + {27'b0, i_validSize_5};
        end
      end
      S_FLUSH: begin
        flush_cnt_d    = (flush_cnt_q == 4'd0) ? 4'd0 : flush_cnt_q - 4'd1;
        drop_pending_d = drop_pending_q && !i_blockValid;
        // Leave on the decremented count so the bubble is exactly FLUSH_CYCLES long.
        if (flush_cnt_d == 4'd0 && !drop_pending_d) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect) begin
      pc_d        = i_beRedirectPc_32;
      flush_cnt_d = FLUSH_LOAD;
      state_d     = S_FLUSH;
      flush_d     = 1'b1;
      // Only a WAIT with no block yet leaves a stale response in flight.
      drop_pending_d = (state_q == S_WAIT) ? !i_blockValid : drop_pending_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      flush_cnt_q    <= 4'd0;
      drop_pending_q <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      flush_cnt_q    <= flush_cnt_d;
      drop_pending_q <= drop_pending_d;
      flush_q        <= flush_d;
    end
  end

  assign o_fetchPc_32 = pc_q;
  assign o_flush      = flush_q;
  assign o_state_2    = state_q;

`ifdef FETCH_PERF_EN
  logic [15:0] fire_cnt_q, fire_cnt_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    fire_cnt_d     = fire_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (o_fire && fire_cnt_q != 16'hFFFF) fire_cnt_d = fire_cnt_q + 16'd1;
    if (redirect && redirect_cnt_q != 16'hFFFF) redirect_cnt_d = redirect_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_cnt_q     <= 16'd0;
      redirect_cnt_q <= 16'd0;
    end else begin
      fire_cnt_q     <= fire_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign o_fireCount_16     = fire_cnt_q;
  assign o_redirectCount_16 = redirect_cnt_q;
`endif

endmodule

// File: doc/fetch_pc_scheduler.md
# fetch_pc_scheduler

Sequences the instruction-fetch front end. It owns the fetch PC register and issues one fetch request at a time to the I-cache. It commits each returned block to the instruction buffer and jump-processing logic with a one-cycle `o_fire` pulse, and picks the next PC with fixed priority: backend redirect, then predicted jump target, then sequential. It also discards in-flight responses and inserts flush bubbles after a backend misprediction.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset.
- `FLUSH_CYCLES`, default 2: bubble cycles after a backend redirect; legal range 1..15, held in a 4-bit counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_icacheReady` in 1: I-cache accepts a request this cycle.
- `o_fetchValid` out 1: fetch request valid.
- `o_fetchPc_32` out 32: fetch request address; always equals the PC register.
- `i_blockValid` in 1: I-cache returns a block. The cache holds it until it is consumed.
- `i_validSize_5` in 5: valid byte count of the returned block.
- `i_predValid` in 1: a jump was predicted inside the returned block.
- `i_predPc_32` in 32: predicted target of that jump.
- `i_bufferFull` in 1: instruction buffer cannot accept a block.
- `i_beRedirect` in 1: backend misprediction.
- `i_beRedirectPc_32` in 32: corrected PC.
- `o_fire` out 1: block committed this cycle. This pulse clocks RAS/BTB updates.
- `o_flush` out 1: one-cycle flush pulse to the buffer and predictors.
- `o_state_2` out 2: current FSM state.

## Operation
- States: IDLE=00, REQ=01, WAIT=10, FLUSH=11.
- Registers: `pc` (32 bits), `state`, `flushCnt` (4 bits), `dropPending` (1 bit).
- IDLE: go to REQ unconditionally on the next clock.
- REQ:
  - `o_fetchValid = !i_beRedirect`.
  - Handshake occurs when `o_fetchValid && i_icacheReady`; then go to WAIT.
- WAIT:
  - Consume condition: `i_blockValid && !i_bufferFull && !i_beRedirect`.
  - On consume: `o_fire = 1` and state goes to REQ.
  - Next `pc` on consume: `i_predPc_32` if `i_predValid`; otherwise `pc + {27'b0, i_validSize_5}`, wrapping modulo 2^32.
  - `i_validSize_5 == 0` gives `pc` unchanged, so the same address is refetched.
  - `i_blockValid && i_bufferFull`: hold in WAIT with no fire; the block is retried each cycle.
- Backend redirect (`i_beRedirect = 1`, sampled in any state other than IDLE) has the highest priority:
  - `pc <= i_beRedirectPc_32`.
  - `flushCnt <= FLUSH_CYCLES`.
  - State goes to FLUSH.
  - `o_flush = 1` in the following cycle.
- `dropPending` on redirect:
  - Redirect in WAIT with `i_blockValid = 0`: set `dropPending`, because a response is still outstanding.
  - Redirect in WAIT with `i_blockValid = 1`: that block is consumed silently (no fire); `dropPending` is not set.
  - Redirect in REQ: no handshake can occur, so `dropPending` is unchanged.
- FLUSH:
  - `o_fetchValid = 0`, `o_fire = 0`.
  - `flushCnt` decrements each cycle, stopping at 0.
  - `i_blockValid` while `dropPending` is set clears `dropPending`; the block is consumed without fire.
  - Go to REQ when `flushCnt == 0 && !dropPending`.
  - A redirect during FLUSH reloads `pc` and `flushCnt` and pulses `o_flush` again; `dropPending` keeps its value.
- `o_fire` is combinational from state and inputs. `o_flush` is registered.

## Timing
- Reset values: state IDLE, `pc = RESET_PC`, `o_fetchPc_32 = RESET_PC`, `o_fetchValid = 0`, `o_fire = 0`, `o_flush = 0`, `o_state_2 = 00`, `flushCnt = 0`, `dropPending = 0`, all perf counters 0.
- After `rst` rises: cycle 1 is IDLE, cycle 2 is REQ with `o_fetchValid = 1`.
- Fire in cycle N: the new PC is on `o_fetchPc_32` with `o_fetchValid = 1` in cycle N+1.
- Redirect sampled at edge N:
  - `o_flush = 1` and `o_fetchPc_32 = redirect PC` during cycle N+1.
  - First new request is in cycle N+1+`FLUSH_CYCLES`, provided `dropPending` has already cleared.
- Reset asserted mid-operation returns all state to reset values immediately. Any outstanding cache response is the cache's responsibility to cancel.

## Configuration
- Macro `FETCH_PERF_EN`: when defined, adds two outputs.
  - `o_fireCount_16` (out, 16 bits) counts `o_fire` pulses.
  - `o_redirectCount_16` (out, 16 bits) counts sampled redirects.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, these ports and counters do not exist. Core behaviour is identical either way.

## Test plan
- Sequential fetch: reset with `RESET_PC = 0x1000`, cache always ready, blocks with size 16 and no prediction -> requests at 0x1000, 0x1010, 0x1020, with one fire per block.
- Predicted jump: block at 0x1000 with `i_predValid = 1`, `i_predPc_32 = 0x2000` -> fire, then the next request is at 0x2000.
- Buffer backpressure: `i_bufferFull = 1` for 3 cycles while `i_blockValid = 1` -> no fire for those 3 cycles, fire on the 4th cycle, PC advances exactly once.
- Redirect while waiting:
  - Stimulus: redirect to 0x3000 in WAIT with no block yet, then the old block returns 1 cycle later.
  - Response: one `o_flush` pulse, no fire for the stale block, request at 0x3000 after 2 bubbles.
- Simultaneous events and wrap:
  - Redirect in the same cycle as a valid block -> redirect wins and the block is consumed silently.
  - PC 0xFFFF_FFF8 with size 16 -> next request at 0x0000_0008.
- With `FETCH_PERF_EN`: 5 fires and 2 redirects -> `o_fireCount_16 = 5`, `o_redirectCount_16 = 2`.
